fault_capture: RTL

Downstream consumer of the sticky fault vector produced by the bitwise high-latch stage. Registers the latched vector, detects newly set bits, records the first fault mask with timestamp, raises a level interrupt with acknowledge, and emits one coalescing event record per new-fault occurrence over a valid/ready interface to the status/AXI readout logic.

---
 rtl/fault_capture_pkg.sv | 20 ++
 rtl/fault_ts_counter.sv | 22 ++
 rtl/fault_capture.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fault_capture_pkg.sv
// fault_capture shared types: IRQ FSM states and event record.
// Optional timestamping is built with FAULT_CAPTURE_TS_EN.
package fault_capture_pkg;

  localparam int FC_WIDTH    = 32;
  localparam int FC_TS_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    ACKED = 2'd2
  } irq_state_t;

  typedef struct packed {
    logic [FC_WIDTH-1:0]    mask;
    logic [FC_TS_WIDTH-1:0] ts;
    logic                   overflow;
  } evt_rec_t;

endpackage

// File: rtl/fault_ts_counter.sv
// Free-running timestamp counter, wraps silently.
// Only instantiated when FAULT_CAPTURE_TS_EN is defined.
module fault_ts_counter
  import fault_capture_pkg::*;
#(
  parameter int TS_WIDTH = FC_TS_WIDTH
) (
  input  logic                clk,
  input  logic                resetn,
  output logic [TS_WIDTH-1:0] count
);

  localparam logic [TS_WIDTH-1:0] ONE =
    {{(TS_WIDTH-1){1'b0}}, 1'b1};

  // count every cycle, modulo 2^TS_WIDTH
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) count <= '0;
    else         count <= count + ONE;
  end

endmodule

// File: rtl/fault_capture.sv
// Sticky fault vector consumer: edge detect, first-fault, irq, event record.
// Define FAULT_CAPTURE_TS_EN to build the timestamp counter.
module fault_capture
  import fault_capture_pkg::*;
#(
  parameter int WIDTH    = FC_WIDTH,
  parameter int TS_WIDTH = FC_TS_WIDTH
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [WIDTH-1:0]    sticky_in,
  input  logic                irq_ack,
  output logic                irq,
  output logic                first_valid,
  output logic [WIDTH-1:0]    first_mask,
  output logic [TS_WIDTH-1:0] first_ts,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [WIDTH-1:0]    evt_mask,
  output logic [TS_WIDTH-1:0] evt_ts,
  output logic                evt_overflow
);

  typedef struct packed {
    logic [WIDTH-1:0]    mask;
    logic [TS_WIDTH-1:0] ts;
    logic                overflow;
  } rec_t;

  logic [WIDTH-1:0]    prev;
  logic [WIDTH-1:0]    new_bits;
  logic                any_new;
  logic [TS_WIDTH-1:0] ts_now;
  irq_state_t          state;
  irq_state_t          state_nxt;
  rec_t                rec;
  logic                rec_v;

  assign new_bits = sticky_in & ~prev;
  assign any_new  = |new_bits;

`ifdef FAULT_CAPTURE_TS_EN
  fault_ts_counter #(
    .TS_WIDTH (TS_WIDTH)
  ) u_ts (
    .clk    (clk),
    .resetn (resetn),
    .count  (ts_now)
  );
`else
  assign ts_now = '0;
`endif

  // remember last sampled vector for rising-bit detection
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) prev <= '0;
    else         prev <= sticky_in;
  end

  // first fault since reset is captured once and held
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      first_valid <= 1'b0;
      first_mask  <= '0;
      first_ts    <= '0;
    end else if (!first_valid && any_new) begin
      first_valid <= 1'b1;
      first_mask  <= new_bits;
      first_ts    <= ts_now;
    end
  end

  // irq state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // irq next state: a new fault always wins over an ack
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_new) state_nxt = PEND;
      PEND:    if (irq_ack && !any_new) state_nxt = ACKED;
      ACKED:   if (any_new) state_nxt = PEND;
      default: state_nxt = IDLE;
    endcase
  end

  // irq output decode
  always_comb begin
    irq = (state == PEND);
  end

  // single-entry event record, coalescing while stalled
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rec_v <= 1'b0;
      rec   <= '0;
    end else if (rec_v && !evt_ready) begin
      if (any_new) begin
        rec.mask     <= rec.mask | new_bits;
        rec.overflow <= 1'b1;
      end
    end else if (any_new) begin
      rec_v        <= 1'b1;
      rec.mask     <= new_bits;
      rec.ts       <= ts_now;
      rec.overflow <= 1'b0;
    end else begin
      rec_v <= 1'b0;
    end
  end

  assign evt_valid    = rec_v;
  assign evt_mask     = rec.mask;
  assign evt_ts       = rec.ts;
  assign evt_overflow = rec.overflow;

endmodule
